// File: rtl/ldpc_pkg.sv
// Shared state type and default constants for the LDPC CNU scheduler.
// The CHK state exists only when LDPC_SCHED_EARLY_TERM_EN is defined.
package ldpc_pkg;

    localparam int LDPC_NUM_ROWS = 3;
    localparam int LDPC_CNU_LAT  = 2;
    localparam int LDPC_MSG_W    = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
`ifdef LDPC_SCHED_EARLY_TERM_EN
        CHK  = 3'd4,
`endif
        DONE = 3'd5
    } sched_state_t;

endpackage

// File: rtl/ldpc_cnu_scheduler.sv
// Row/iteration sequencer for a shared 6-input check-node unit in layered min-sum LDPC decoding.
// Optional syndrome-based early termination is enabled by defining LDPC_SCHED_EARLY_TERM_EN.
import ldpc_pkg::*;

module ldpc_cnu_scheduler #(
    parameter int NUM_ROWS = LDPC_NUM_ROWS,
    parameter int ROW_W    = 2,
    parameter int CNU_LAT  = LDPC_CNU_LAT,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] max_iter,
    output logic              rd_en,
    output logic              wr_en,
    output logic [ROW_W-1:0]  row_addr,
    output logic              syn_req,
    input  logic              syn_valid,
    input  logic              syn_ok,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_count
);

    localparam int WAIT_W = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    sched_state_t      state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] max_q, max_d;
    logic              converged_q, converged_d;
    logic [ITER_W-1:0] iter_inc;

    assign iter_inc = iter_q + ITER_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            wait_q      <= '0;
            iter_q      <= '0;
            max_q       <= ITER_W'(1);
            converged_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            wait_q      <= wait_d;
            iter_q      <= iter_d;
            max_q       <= max_d;
            converged_q <= converged_d;
        end
    end

    // abort overrides every transition but leaves iteration count and convergence flag alone
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        wait_d      = wait_q;
        iter_d      = iter_q;
        max_d       = max_q;
        converged_d = converged_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_d       = '0;
                        iter_d      = '0;
                        converged_d = 1'b0;
                        max_d       = (max_iter == '0) ? ITER_W'(1) : max_iter;
                        state_d     = RD;
                    end
                end
                RD: begin
                    wait_d  = WAIT_W'(CNU_LAT - 1);
                    state_d = WAIT;
                end
                WAIT: begin
                    if (wait_q == '0) begin
                        state_d = WR;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                WR: begin
                    if (row_q == LAST_ROW) begin
                        iter_d = iter_inc;
`ifdef LDPC_SCHED_EARLY_TERM_EN
                        state_d = CHK;
`else
                        if (iter_inc == max_q) begin
                            state_d = DONE;
                        end else begin
                            row_d   = '0;
                            state_d = RD;
                        end
`endif
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = RD;
                    end
                end
`ifdef LDPC_SCHED_EARLY_TERM_EN
                CHK: begin
                    if (syn_valid) begin
                        if (syn_ok) begin
                            converged_d = 1'b1;
                            state_d     = DONE;
                        end else if (iter_q == max_q) begin
                            state_d = DONE;
                        end else begin
                            row_d   = '0;
                            state_d = RD;
                        end
                    end
                end
`endif
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rd_en      = (state_q == RD);
    assign wr_en      = (state_q == WR);
    assign row_addr   = row_q;
    assign done       = (state_q == DONE);
    assign converged  = converged_q;
    assign iter_count = iter_q;

`ifdef LDPC_SCHED_EARLY_TERM_EN
    assign syn_req = (state_q == CHK);
    assign busy    = (state_q == RD) || (state_q == WAIT) || (state_q == WR) || (state_q == CHK);
`else
    logic unused_syn;
    assign unused_syn = syn_valid | syn_ok;
    assign syn_req    = 1'b0;
    assign busy       = (state_q == RD) || (state_q == WAIT) || (state_q == WR);
`endif

endmodule

// File: tb/tb_ldpc_cnu_scheduler.sv
// Self-checking bench for ldpc_cnu_scheduler; the expected schedule is derived arithmetically
// (row = k/4, rd at k%4==0, wr at k%4==3) and covers LDPC_SCHED_EARLY_TERM_EN when it is defined.
module tb_ldpc_cnu_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] max_iter = 8'd0;
    logic       rd_en, wr_en, syn_req, busy, done, converged;
    logic [1:0] row_addr;
    logic       syn_valid = 1'b0;
    logic       syn_ok = 1'b0;
    logic [7:0] iter_count;

    int total = 0;
    int bad = 0;

    localparam int ROW_CYCLES  = 4;
    localparam int ITER_CYCLES = 12;

    ldpc_cnu_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .max_iter(max_iter),
        .rd_en(rd_en), .wr_en(wr_en), .row_addr(row_addr), .syn_req(syn_req),
        .syn_valid(syn_valid), .syn_ok(syn_ok), .busy(busy), .done(done),
        .converged(converged), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag, input int expIter, input logic expConv);
        checkOutput({tag, " rd_en"}, 32'(rd_en), 32'd0);
        checkOutput({tag, " wr_en"}, 32'(wr_en), 32'd0);
        checkOutput({tag, " syn_req"}, 32'(syn_req), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " iter_count"}, 32'(iter_count), 32'(expIter));
        checkOutput({tag, " converged"}, 32'(converged), 32'(expConv));
    endtask

    task automatic checkRowCycle(input int it, input int k);
        string t;
        t = $sformatf("it%0d k%0d", it, k);
        checkOutput({t, " rd_en"}, 32'(rd_en), (k % ROW_CYCLES == 0) ? 32'd1 : 32'd0);
        checkOutput({t, " wr_en"}, 32'(wr_en), (k % ROW_CYCLES == ROW_CYCLES - 1) ? 32'd1 : 32'd0);
        checkOutput({t, " row_addr"}, 32'(row_addr), 32'(k / ROW_CYCLES));
        checkOutput({t, " busy"}, 32'(busy), 32'd1);
        checkOutput({t, " done"}, 32'(done), 32'd0);
        checkOutput({t, " syn_req"}, 32'(syn_req), 32'd0);
        checkOutput({t, " iter_count"}, 32'(iter_count), 32'(it));
    endtask

    task automatic checkChkCycle(input int n);
        string t;
        t = $sformatf("chk%0d", n);
        checkOutput({t, " syn_req"}, 32'(syn_req), 32'd1);
        checkOutput({t, " rd_en"}, 32'(rd_en), 32'd0);
        checkOutput({t, " wr_en"}, 32'(wr_en), 32'd0);
        checkOutput({t, " busy"}, 32'(busy), 32'd1);
        checkOutput({t, " iter_count"}, 32'(iter_count), 32'(n));
    endtask

    // Runs one decode from a start pulse; stops early (leaving the DUT mid-row) when stopIter/stopK is hit.
    task automatic applyStimulus(input logic [7:0] maxIter, input int okIter, input int stopIter, input int stopK);
        int  effMax;
        int  finalIter;
        logic expConv;
        bit  finished;
        effMax    = (maxIter == 8'd0) ? 1 : int'(maxIter);
        finalIter = effMax;
        expConv   = 1'b0;
        finished  = 1'b0;
        $display("[TB] run max_iter=%0d syn_ok_at=%0d", maxIter, okIter);
        max_iter = maxIter;
        start = 1'b1;
        tick();
        start = 1'b0;
        max_iter = 8'($urandom);
        for (int it = 0; it < effMax && !finished; it++) begin
            for (int k = 0; k < ITER_CYCLES; k++) begin
                checkRowCycle(it, k);
                if (it == stopIter && k == stopK) return;
                start = ($urandom_range(0, 3) == 0);
                tick();
                start = 1'b0;
            end
`ifdef LDPC_SCHED_EARLY_TERM_EN
            begin
                int d;
                d = $urandom_range(0, 2);
                for (int j = 0; j < d; j++) begin
                    checkChkCycle(it + 1);
                    syn_ok = 1'($urandom_range(0, 1));
                    tick();
                end
                checkChkCycle(it + 1);
                syn_valid = 1'b1;
                syn_ok = (it + 1 == okIter);
                tick();
                syn_valid = 1'b0;
                syn_ok = 1'b0;
                if (it + 1 == okIter) begin
                    expConv   = 1'b1;
                    finalIter = it + 1;
                    finished  = 1'b1;
                end
            end
`endif
        end
        checkOutput("done pulse", 32'(done), 32'd1);
        checkOutput("done busy", 32'(busy), 32'd0);
        checkOutput("done rd_en", 32'(rd_en), 32'd0);
        checkOutput("done wr_en", 32'(wr_en), 32'd0);
        checkOutput("done iter_count", 32'(iter_count), 32'(finalIter));
        checkOutput("done converged", 32'(converged), 32'(expConv));
        start = 1'b1;
        tick();
        start = 1'b0;
        checkIdle("after done", finalIter, expConv);
        tick();
        checkIdle("start at done ignored", finalIter, expConv);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        checkIdle("reset", 0, 1'b0);
        checkOutput("reset row_addr", 32'(row_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checkIdle("post reset", 0, 1'b0);

        applyStimulus(8'd2, 0, -1, -1);
        tick();
        applyStimulus(8'd0, 0, -1, -1);
        tick();
        repeat (3) begin
            applyStimulus(8'($urandom_range(1, 4)), $urandom_range(0, 4), -1, -1);
            repeat ($urandom_range(0, 2)) tick();
        end
`ifdef LDPC_SCHED_EARLY_TERM_EN
        applyStimulus(8'd5, 2, -1, -1);
        tick();
        applyStimulus(8'd3, 0, -1, -1);
        tick();
`endif

        applyStimulus(8'd3, 0, 1, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkIdle("abort", 1, 1'b0);
        tick();
        checkIdle("abort no done", 1, 1'b0);
        applyStimulus(8'd1, 0, -1, -1);
        tick();

        applyStimulus(8'd3, 0, 1, 7);
        #2 rst = 1'b1;
        #1;
        checkIdle("async reset", 0, 1'b0);
        checkOutput("async reset row_addr", 32'(row_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        checkIdle("held reset", 0, 1'b0);
        tick();
        checkIdle("idle after reset", 0, 1'b0);
        applyStimulus(8'd1, 1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
